// File: rtl/uart_xcvr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_xcvr_pkg
// Purpose  : State encodings and baud divider helper shared by the UART
//            transceiver. The parity states exist only when
//            UART_XCVR_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package uart_xcvr_pkg;

`ifdef UART_XCVR_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd4
    } tx_state_t;
`endif

    // Clocks per oversample tick, never below one.
    function automatic int calc_div(input int clockfrq, input int baudrate, input int oversample);
        int div;
        div = clockfrq / (baudrate * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_xcvr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_xcvr_fifo
// Purpose  : Receive FIFO with a registered head word; a push into a full
//            FIFO succeeds only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_xcvr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw-1:0]  w_rd_next;
    logic [c_aw:0]    r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign w_rd_next = r_rd_ptr + c_aw'(1);
    assign rdata     = r_rdata;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (c_aw+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (c_aw+1)'(1);
            end
            // Keep the head register equal to whatever word sits at the read pointer.
            if (w_do_pop) begin
                if (r_count == (c_aw+1)'(1)) begin
                    if (w_do_push) begin
                        r_rdata <= wdata;
                    end
                end else begin
                    r_rdata <= r_mem[w_rd_next];
                end
            end else if (empty && w_do_push) begin
                r_rdata <= wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
// Module   : uart_xcvr
// Purpose  : Full-duplex UART with oversampled receiver and RX FIFO.
//            Define UART_XCVR_PARITY_EN to add a parity bit to both directions.
// Revision : 1.0 - initial release
// ============================================================================
module uart_xcvr
    import uart_xcvr_pkg::*;
#(
    parameter int CLOCKFRQ      = 240000000,
    parameter int BAUDRATE      = 12000000,
    parameter int OVERSAMPLE    = 4,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 16,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 tx_busy,
    output logic                 rx_busy
);

    localparam int                   c_div      = calc_div(CLOCKFRQ, BAUDRATE, OVERSAMPLE);
    localparam int                   c_div_w    = $clog2(c_div + 1);
    localparam logic [c_div_w-1:0]   c_div_max  = c_div_w'(c_div - 1);
    localparam logic [3:0]           c_os_max   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]           c_os_half  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]           c_last_bit = 4'(DATA_BITS - 1);
    localparam logic                 c_last_stp = 1'(STOP_BITS - 1);

    // ---------------------------------------------------------------- RX sync
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------ RX machine
    rx_state_t              r_rx_state;
    logic [c_div_w-1:0]     r_rx_tick_cnt;
    logic [3:0]             r_rx_os_cnt;
    logic [3:0]             r_rx_bit_idx;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   r_rx_busy;
    logic                   r_push;
    logic [DATA_BITS-1:0]   r_push_data;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   w_rx_tick;
    logic                   w_rx_sample;
`ifdef UART_XCVR_PARITY_EN
    logic                   r_rx_par;
    logic                   w_par_bad;
    assign w_par_bad = ((^r_rx_shift) ^ 1'(PARITY_ODD)) != r_rx_par;
`endif

    assign w_rx_tick   = (r_rx_tick_cnt == '0);
    assign w_rx_sample = w_rx_tick && (r_rx_os_cnt == '0);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_rx_state    <= RX_IDLE;
            r_rx_tick_cnt <= c_div_max;
            r_rx_os_cnt   <= c_os_max;
            r_rx_bit_idx  <= '0;
            r_rx_shift    <= '0;
            r_rx_busy     <= 1'b0;
            r_push        <= 1'b0;
            r_push_data   <= '0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
            r_rx_par      <= 1'b0;
`endif
        end else begin
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            if (r_rx_state != RX_IDLE) begin
                r_rx_tick_cnt <= w_rx_tick ? c_div_max : r_rx_tick_cnt - c_div_w'(1);
                if (w_rx_tick) begin
                    r_rx_os_cnt <= (r_rx_os_cnt == '0) ? c_os_max : r_rx_os_cnt - 4'd1;
                end
            end
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_state    <= RX_START;
                        r_rx_tick_cnt <= c_div_max;
                        r_rx_os_cnt   <= c_os_half;
                        r_rx_busy     <= 1'b1;
                    end
                end
                RX_START: begin
                    if (w_rx_sample) begin
                        r_rx_bit_idx <= '0;
                        if (!r_rx_sync) begin
                            r_rx_state <= RX_DATA;
                        end else begin
                            r_rx_state <= RX_IDLE;
                            r_rx_busy  <= 1'b0;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rx_sample) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit_idx == c_last_bit) begin
`ifdef UART_XCVR_PARITY_EN
                            r_rx_state <= RX_PARITY;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end else begin
                            r_rx_bit_idx <= r_rx_bit_idx + 4'd1;
                        end
                    end
                end
`ifdef UART_XCVR_PARITY_EN
                RX_PARITY: begin
                    if (w_rx_sample) begin
                        r_rx_par   <= r_rx_sync;
                        r_rx_state <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (w_rx_sample) begin
`ifdef UART_XCVR_PARITY_EN
                        r_parity_err <= w_par_bad;
`endif
                        if (r_rx_sync) begin
                            r_push      <= 1'b1;
                            r_push_data <= r_rx_shift;
                            r_rx_state  <= RX_IDLE;
                            r_rx_busy   <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_rx_state  <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    // A held-low line (break) parks here until it returns high.
                    if (r_rx_sync) begin
                        r_rx_state <= RX_IDLE;
                        r_rx_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                    r_rx_busy  <= 1'b0;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- RX FIFO
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_pop;
    logic r_overrun;

    assign rx_valid = !w_fifo_empty;
    assign w_pop    = rx_valid && rx_ready;

    uart_xcvr_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nRst  (nRst),
        .push  (r_push),
        .wdata (r_push_data),
        .pop   (w_pop),
        .rdata (rx_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_push && w_fifo_full && !w_pop;
        end
    end

    // ------------------------------------------------------------ TX machine
    tx_state_t              r_tx_state;
    logic [c_div_w-1:0]     r_tx_tick_cnt;
    logic [3:0]             r_tx_os_cnt;
    logic [3:0]             r_tx_bit_idx;
    logic                   r_tx_stop_idx;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic                   r_tx;
    logic                   r_tx_ready;
    logic                   r_tx_busy;
    logic                   w_tx_tick;
    logic                   w_tx_bit_end;
`ifdef UART_XCVR_PARITY_EN
    logic                   r_tx_par;
`endif

    assign w_tx_tick    = (r_tx_tick_cnt == '0);
    assign w_tx_bit_end = w_tx_tick && (r_tx_os_cnt == '0);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_tx_state    <= TX_IDLE;
            r_tx_tick_cnt <= c_div_max;
            r_tx_os_cnt   <= c_os_max;
            r_tx_bit_idx  <= '0;
            r_tx_stop_idx <= 1'b0;
            r_tx_shift    <= '0;
            r_tx          <= 1'b1;
            r_tx_ready    <= 1'b0;
            r_tx_busy     <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
            r_tx_par      <= 1'b0;
`endif
        end else begin
            if (r_tx_state != TX_IDLE) begin
                r_tx_tick_cnt <= w_tx_tick ? c_div_max : r_tx_tick_cnt - c_div_w'(1);
                if (w_tx_tick) begin
                    r_tx_os_cnt <= (r_tx_os_cnt == '0) ? c_os_max : r_tx_os_cnt - 4'd1;
                end
            end
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_valid && r_tx_ready) begin
                        r_tx_state    <= TX_START;
                        r_tx_ready    <= 1'b0;
                        r_tx_busy     <= 1'b1;
                        r_tx          <= 1'b0;
                        r_tx_shift    <= tx_data;
                        r_tx_tick_cnt <= c_div_max;
                        r_tx_os_cnt   <= c_os_max;
`ifdef UART_XCVR_PARITY_EN
                        r_tx_par      <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx         <= r_tx_shift[0];
                        r_tx_shift   <= r_tx_shift >> 1;
                        r_tx_bit_idx <= '0;
                        r_tx_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        if (r_tx_bit_idx == c_last_bit) begin
`ifdef UART_XCVR_PARITY_EN
                            r_tx       <= r_tx_par;
                            r_tx_state <= TX_PARITY;
`else
                            r_tx          <= 1'b1;
                            r_tx_stop_idx <= 1'b0;
                            r_tx_state    <= TX_STOP;
`endif
                        end else begin
                            r_tx         <= r_tx_shift[0];
                            r_tx_shift   <= r_tx_shift >> 1;
                            r_tx_bit_idx <= r_tx_bit_idx + 4'd1;
                        end
                    end
                end
`ifdef UART_XCVR_PARITY_EN
                TX_PARITY: begin
                    if (w_tx_bit_end) begin
                        r_tx          <= 1'b1;
                        r_tx_stop_idx <= 1'b0;
                        r_tx_state    <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_tx_bit_end) begin
                        if (r_tx_stop_idx == c_last_stp) begin
                            r_tx_state <= TX_IDLE;
                            r_tx_ready <= 1'b1;
                            r_tx_busy  <= 1'b0;
                        end else begin
                            r_tx_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_tx       <= 1'b1;
                    r_tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign tx           = r_tx;
    assign tx_ready     = r_tx_ready;
    assign tx_busy      = r_tx_busy;
    assign rx_busy      = r_rx_busy;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;
`ifdef UART_XCVR_PARITY_EN
    assign rx_parity_err = r_parity_err;
`else
    logic w_unused_parity;
    assign w_unused_parity = r_parity_err ^ 1'(PARITY_ODD);
    assign rx_parity_err   = 1'b0;
`endif

endmodule
`default_nettype wire
